sa_drain: RTL and testbench

Output collector for the systolic array: it is the receiving end of the partial-sum (`c`) protocol leaving the bottom PE row. Column `j` of a result row arrives `j` cycles after column 0. The block deskews the `N` columns into one aligned row, buffers rows in a FIFO, and presents them downstream with a valid/ready handshake. The array has no backpressure, so the block flags overflow and valid-pattern errors instead of stalling.

---
 rtl/sa_drain.sv | 133 +++++++++++++
 tb/tb_sa_drain.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_drain.sv
// Systolic-array output collector: deskews N skewed column results into aligned rows,
// buffers them in a FIFO and presents them downstream; SA_DRAIN_VLD_CHK_EN enables valid checks.
module sa_drain #(
  parameter int unsigned N       = 4,
  parameter int unsigned O_WIDTH = 31,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N-1:0]               i_c_vld,
  input  logic [N*O_WIDTH-1:0]       i_c,
  output logic                       o_vld,
  input  logic                       i_rdy,
  output logic [N*O_WIDTH-1:0]       o_row,
  output logic [$clog2(DEPTH+1)-1:0] o_cnt,
  output logic                       o_ovf,
  output logic                       o_err,
  input  logic                       i_clr
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [N*O_WIDTH-1:0] row_dat;
  logic                 row_vld;

  // Column j is delayed N-1-j cycles so every column of a row lines up with column N-1.
  for (genvar j = 0; j < N; j++) begin : g_col
    if (j == N - 1) begin : g_pass
      assign row_dat[j*O_WIDTH +: O_WIDTH] = i_c[j*O_WIDTH +: O_WIDTH];
    end else begin : g_dly
      localparam int L = N - 1 - j;
      logic [O_WIDTH-1:0] dat_q [L];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < L; k++) dat_q[k] <= '0;
        end else begin
          dat_q[0] <= i_c[j*O_WIDTH +: O_WIDTH];
          for (int k = 1; k < L; k++) dat_q[k] <= dat_q[k-1];
        end
      end

      assign row_dat[j*O_WIDTH +: O_WIDTH] = dat_q[L-1];
    end
  end

  // Column N-1 is unregistered, so its raw valid is already the aligned row valid.
  assign row_vld = i_c_vld[N-1];

  logic [N*O_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        cnt_q;
  logic                 ovf_q;
  logic                 full, pop, push, drop;

  always_comb begin
    full = (cnt_q == CW'(DEPTH));
    pop  = (cnt_q != '0) & i_rdy;
    push = row_vld & (~full | pop);
    drop = row_vld & full & ~pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= row_dat;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      // A new drop in the same cycle as a clear keeps the flag set.
      ovf_q <= drop | (ovf_q & ~i_clr);
    end
  end

  assign o_vld = (cnt_q != '0);
  assign o_row = mem_q[rd_ptr_q];
  assign o_cnt = cnt_q;
  assign o_ovf = ovf_q;

`ifdef SA_DRAIN_VLD_CHK_EN
  logic [N-1:0] dsk_vld;
  logic         mismatch;
  logic         err_q;

  for (genvar j = 0; j < N; j++) begin : g_vld
    if (j == N - 1) begin : g_pass
      assign dsk_vld[j] = i_c_vld[j];
    end else begin : g_dly
      localparam int L = N - 1 - j;
      logic vld_q [L];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < L; k++) vld_q[k] <= 1'b0;
        end else begin
          vld_q[0] <= i_c_vld[j];
          for (int k = 1; k < L; k++) vld_q[k] <= vld_q[k-1];
        end
      end

      assign dsk_vld[j] = vld_q[L-1];
    end
  end

  assign mismatch = (dsk_vld != '0) & (dsk_vld != '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= mismatch | (err_q & ~i_clr);
    end
  end

  assign o_err = err_q;
`else
  // Only column N-1's valid matters when the consistency check is compiled out.
  logic unused_vld;
  assign unused_vld = ^i_c_vld[N-2:0];
  assign o_err      = 1'b0;
`endif

endmodule

// File: tb/tb_sa_drain.sv
// Directed bench for sa_drain with a queue-based row model checked every cycle.
module tb_sa_drain;

  localparam int N     = 4;
  localparam int W     = 31;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef logic [N*W-1:0] row_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  i_c_vld = '0;
  row_t          i_c = '0;
  logic          o_vld;
  logic          i_rdy = 1'b1;
  row_t          o_row;
  logic [CW-1:0] o_cnt;
  logic          o_ovf;
  logic          o_err;
  logic          i_clr = 1'b0;

  sa_drain #(
    .N      (N),
    .O_WIDTH(W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_c_vld(i_c_vld),
    .i_c    (i_c),
    .o_vld  (o_vld),
    .i_rdy  (i_rdy),
    .o_row  (o_row),
    .o_cnt  (o_cnt),
    .o_ovf  (o_ovf),
    .o_err  (o_err),
    .i_clr  (i_clr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: history of raw inputs by age, plus a queue standing in for the FIFO.
  logic [N-1:0] hv [N];
  row_t         hd [N];
  row_t         mq [$];
  logic         m_ovf = 1'b0;
  logic         m_err = 1'b0;
  logic [N-1:0] al_v;
  row_t         al_d;
  bit           m_pop, m_full;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_vld", o_vld, 0);
      chk("rst_row", o_row, 0);
      chk("rst_cnt", o_cnt, 0);
      chk("rst_ovf", o_ovf, 0);
      chk("rst_err", o_err, 0);
      mq.delete();
      for (int a = 0; a < N; a++) begin
        hv[a] = '0;
        hd[a] = '0;
      end
      m_ovf = 1'b0;
      m_err = 1'b0;
    end else begin
      chk("vld", o_vld, mq.size() != 0);
      chk("cnt", o_cnt, mq.size());
      if (mq.size() != 0) chk("row", o_row, mq[0]);
      chk("ovf", o_ovf, m_ovf);
      chk("err", o_err, m_err);
      // Column j of a row arrives j cycles late; it is aligned when its age is N-1-j.
      for (int a = N - 1; a > 0; a--) begin
        hv[a] = hv[a-1];
        hd[a] = hd[a-1];
      end
      hv[0] = i_c_vld;
      hd[0] = i_c;
      for (int j = 0; j < N; j++) begin
        al_v[j]         = hv[N-1-j][j];
        al_d[j*W +: W]  = hd[N-1-j][j*W +: W];
      end
      m_pop  = (mq.size() != 0) && i_rdy;
      m_full = (mq.size() == DEPTH);
`ifdef SA_DRAIN_VLD_CHK_EN
      if (al_v != '0 && al_v != '1) m_err = 1'b1;
      else if (i_clr) m_err = 1'b0;
`endif
      if (al_v[N-1] && m_full && !m_pop) m_ovf = 1'b1;
      else if (i_clr) m_ovf = 1'b0;
      if (m_pop) void'(mq.pop_front());
      if (al_v[N-1] && (!m_full || m_pop)) mq.push_back(al_d);
    end
  end

  int vld_seen = 0;
  int max_cnt  = 0;
  always @(negedge clk) begin
    if (rst_n && o_vld) vld_seen++;
    if (int'(o_cnt) > max_cnt) max_cnt = int'(o_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] cval(input int r, input int j);
    return W'(r * 'h101 + j * 'h1000000);
  endfunction

  function automatic row_t rowval(input int r);
    row_t v;
    for (int j = 0; j < N; j++) v[j*W +: W] = cval(r, j);
    return v;
  endfunction

  // Drive n back-to-back skewed rows; i_rdy takes rdy_align in cycles where a row aligns.
  task automatic drive_rows(input int first, input int n, input logic rdy_base,
                            input logic rdy_align, input int drop_row, input int drop_col);
    for (int c = 0; c < n + N - 1; c++) begin
      i_c_vld = '0;
      i_c     = '0;
      i_rdy   = rdy_base;
      for (int j = 0; j < N; j++) begin
        int r;
        r = c - j;
        if (r >= 0 && r < n) begin
          if (!(r == drop_row && j == drop_col)) i_c_vld[j] = 1'b1;
          i_c[j*W +: W] = cval(first + r, j);
          if (j == N - 1) i_rdy = rdy_align;
        end
      end
      tick();
    end
    i_c_vld = '0;
    i_c     = '0;
    i_rdy   = rdy_base;
  endtask

  initial begin
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single skewed row.
    for (int c = 0; c < N; c++) begin
      i_c_vld = '0;
      i_c     = '0;
      i_c_vld[c] = 1'b1;
      i_c[c*W +: W] = W'((c + 1) * 'h11);
      tick();
    end
    i_c_vld = '0;
    i_c     = '0;
    chk("single_vld", o_vld, 1);
    chk("single_row", o_row, {31'h44, 31'h33, 31'h22, 31'h11});
    chk("single_cnt1", o_cnt, 1);
    tick();
    chk("single_cnt0", o_cnt, 0);
    chk("single_vld0", o_vld, 0);

    // Streaming.
    vld_seen = 0;
    max_cnt  = 0;
    drive_rows(1, 8, 1'b1, 1'b1, -1, -1);
    repeat (3) tick();
    chk("stream_rows", vld_seen, 8);
    chk("stream_cnt_le1", max_cnt <= 1, 1);
    chk("stream_ovf", o_ovf, 0);

    // Backpressure and overflow.
    drive_rows(20, 5, 1'b0, 1'b0, -1, -1);
    repeat (2) tick();
    chk("ovf_cnt", o_cnt, 4);
    chk("ovf_flag", o_ovf, 1);
    chk("ovf_head", o_row, rowval(20));
    chk("ovf_head_lit", o_row[W-1:0], 31'h1414);
    vld_seen = 0;
    i_rdy = 1'b1;
    repeat (6) tick();
    chk("ovf_drained", vld_seen, 4);
    chk("ovf_cnt0", o_cnt, 0);
    chk("ovf_sticky", o_ovf, 1);
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    chk("ovf_clr", o_ovf, 0);

    // Full plus simultaneous pop.
    drive_rows(40, 4, 1'b0, 1'b0, -1, -1);
    repeat (2) tick();
    chk("fullpop_pre", o_cnt, 4);
    drive_rows(50, 1, 1'b0, 1'b1, -1, -1);
    chk("fullpop_cnt", o_cnt, 4);
    chk("fullpop_ovf", o_ovf, 0);
    chk("fullpop_head", o_row, rowval(41));
    i_rdy = 1'b1;
    repeat (6) tick();
    chk("fullpop_cnt0", o_cnt, 0);

    // Valid mismatch on column 2.
    drive_rows(60, 1, 1'b1, 1'b1, 0, 2);
    tick();
`ifdef SA_DRAIN_VLD_CHK_EN
    chk("vmis_err", o_err, 1);
`else
    chk("vmis_err", o_err, 0);
`endif
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    chk("vmis_clr", o_err, 0);
    repeat (2) tick();
    chk("vmis_cnt0", o_cnt, 0);

    // Reset with rows buffered and one in flight.
    drive_rows(70, 3, 1'b0, 1'b0, -1, -1);
    tick();
    chk("rstmid_cnt3", o_cnt, 3);
    i_c_vld = 4'b0001;
    i_c[W-1:0] = cval(80, 0);
    tick();
    i_c_vld = '0;
    i_c     = '0;
    rst_n   = 1'b0;
    #1;
    chk("rstmid_vld", o_vld, 0);
    chk("rstmid_cnt", o_cnt, 0);
    chk("rstmid_row", o_row, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    i_rdy = 1'b1;
    vld_seen = 0;
    repeat (8) tick();
    chk("rstmid_no_stale", vld_seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
